router_node_p: RTL and testbench

Parametrised 5-port wormhole mesh router node, the successor to the fixed 16-bit, 5-interface node. Every input port has a FIFO of configurable depth and width. Each head flit is routed dimension-order (X then Y) against the node's own coordinates. Each output has a round-robin arbiter that locks the output for a whole packet. The router sits at every mesh tile and links to its four neighbours and the local core.

---
 rtl/router_node_p.sv | 198 +++++++++++++++++++
 tb/tb_router_node_p.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_node_p.sv
// 5-port wormhole mesh router: per-input FIFOs, XY routing, per-output round-robin packet locking.
// Define ROUTER_STATS_EN to add saturating per-output flit counters on the flit_cnt port.

module router_node_p #(
    parameter int NODE_X     = 0,
    parameter int NODE_Y     = 0,
    parameter int COORD_W    = 4,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          in_valid,
    input  logic [5*DATA_W-1:0] in_data,
    output logic [4:0]          in_full,
    output logic [4:0]          out_valid,
    output logic [5*DATA_W-1:0] out_data,
    input  logic [4:0]          out_full
`ifdef ROUTER_STATS_EN
    ,
    output logic [5*CNT_W-1:0]  flit_cnt
`endif
);

    localparam int NP    = 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DST_W = 2 * COORD_W;
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(NODE_Y);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_L = 3'd4;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    logic [DATA_W-1:0]  mem_q    [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q [NP];
    logic [PTR_W-1:0]   wr_ptr_q [NP];
    logic [PTR_W:0]     count_q  [NP];
    logic [NP-1:0]      push, pop, empty;
    logic [DATA_W-1:0]  head     [NP];
    logic [COORD_W-1:0] dest_x   [NP];
    logic [COORD_W-1:0] dest_y   [NP];
    logic [LEN_W-1:0]   eff_len  [NP];
    logic [2:0]         route    [NP];
    logic [DATA_W-1:0]  unused_head_bits;

    state_e             state_q [NP], state_d [NP];
    logic [LEN_W-1:0]   rem_q   [NP], rem_d   [NP];
    logic [NP-1:0]      lock_q, lock_d;
    logic [2:0]         owner_q [NP], owner_d [NP];
    logic [2:0]         rr_q    [NP], rr_d    [NP];
    logic [2:0]         src     [NP];
    logic [NP-1:0]      send, grant;

    // Head-flit decode: XY route and effective length (L=0 behaves as a single-flit packet).
    always_comb begin
        unused_head_bits = '0;
        for (int p = 0; p < NP; p++) begin
            empty[p]   = (count_q[p] == '0);
            in_full[p] = (count_q[p] == FULL_CNT);
            push[p]    = in_valid[p] && !in_full[p];
            head[p]    = mem_q[p][rd_ptr_q[p]];
            dest_x[p]  = head[p][DST_W-1:COORD_W];
            dest_y[p]  = head[p][COORD_W-1:0];
            eff_len[p] = (head[p][LEN_W+DST_W-1:DST_W] == '0) ? LEN_W'(1)
                                                              : head[p][LEN_W+DST_W-1:DST_W];
            if (dest_x[p] > MY_X)      route[p] = P_E;
            else if (dest_x[p] < MY_X) route[p] = P_W;
            else if (dest_y[p] > MY_Y) route[p] = P_N;
            else if (dest_y[p] < MY_Y) route[p] = P_S;
            else                       route[p] = P_L;
            unused_head_bits = unused_head_bits ^ head[p];
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        send      = '0;
        grant     = '0;
        pop       = '0;
        out_valid = '0;
        out_data  = '0;
        for (int o = 0; o < NP; o++) begin
            src[o] = owner_q[o];
            if (lock_q[o]) begin
                send[o] = !empty[owner_q[o]] && !out_full[o];
            end else if (!out_full[o]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= NP) idx = idx - NP;
                    if (!grant[o] && state_q[idx] == IDLE && !empty[idx] && route[idx] == 3'(o)) begin
                        grant[o] = 1'b1;
                        src[o]   = 3'(idx);
                    end
                end
                send[o] = grant[o];
            end
            if (send[o]) begin
                pop[src[o]]                   = 1'b1;
                out_valid[o]                  = 1'b1;
                out_data[o*DATA_W +: DATA_W]  = head[src[o]];
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        for (int i = 0; i < NP; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (pop[i]) begin
                if (state_q[i] == IDLE) begin
                    if (eff_len[i] != LEN_W'(1)) begin
                        state_d[i] = LOCKED;
                        rem_d[i]   = eff_len[i] - LEN_W'(1);
                    end
                end else begin
                    rem_d[i] = rem_q[i] - LEN_W'(1);
                    if (rem_q[i] == LEN_W'(1)) state_d[i] = IDLE;
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            if (grant[o]) begin
                rr_d[o] = (src[o] == 3'd4) ? 3'd0 : src[o] + 3'd1;
                if (eff_len[src[o]] != LEN_W'(1)) begin
                    lock_d[o]  = 1'b1;
                    owner_d[o] = src[o];
                end
            end else if (lock_q[o] && send[o] && rem_q[owner_q[o]] == LEN_W'(1)) begin
                lock_d[o] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            for (int p = 0; p < NP; p++) begin
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                count_q[p]  <= '0;
                state_q[p]  <= IDLE;
                rem_q[p]    <= '0;
                owner_q[p]  <= '0;
                rr_q[p]     <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
                if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
                count_q[p] <= count_q[p] + (PTR_W+1)'(push[p]) - (PTR_W+1)'(pop[p]);
                state_q[p] <= state_d[p];
                rem_q[p]   <= rem_d[p];
                owner_q[p] <= owner_d[p];
                rr_q[p]    <= rr_d[p];
            end
        end
    end

    // NOTE: FIFO storage is not reset; emptiness is defined by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem_q[p][wr_ptr_q[p]] <= in_data[p*DATA_W +: DATA_W];
        end
    end

`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] cnt_q [NP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && cnt_q[o] != '1) cnt_q[o] <= cnt_q[o] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        flit_cnt = '0;
        for (int o = 0; o < NP; o++) flit_cnt[o*CNT_W +: CNT_W] = cnt_q[o];
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_router_node_p.sv
// Self-checking bench for router_node_p at node (1,1): directed scenarios plus a randomized
// phase scored against a packet-level queue model. Stats checks compile with ROUTER_STATS_EN.

module tb_router_node_p;

    localparam int NP = 5;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      in_valid, in_full, out_valid, out_full;
    logic [5*DW-1:0] in_data, out_data;
    logic [DW-1:0]   in_d  [NP];
    logic [DW-1:0]   out_d [NP];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int p = 0; p < NP; p++) begin
            in_data[p*DW +: DW] = in_d[p];
            out_d[p]            = out_data[p*DW +: DW];
        end
    end

`ifdef ROUTER_STATS_EN
    logic [5*16-1:0] flit_cnt;
    logic [5*2-1:0]  sat_cnt;
    logic [4:0]      sat_in_full, sat_out_valid;
    logic [5*DW-1:0] sat_out_data;

    router_node_p #(.NODE_X(1), .NODE_Y(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_full(sat_in_full),
        .out_valid(sat_out_valid), .out_data(sat_out_data), .out_full(out_full), .flit_cnt(sat_cnt)
    );
`endif

    router_node_p #(.NODE_X(1), .NODE_Y(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_full  (in_full),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_full (out_full)
`ifdef ROUTER_STATS_EN
        ,
        .flit_cnt (flit_cnt)
`endif
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output-valid vector plus the data on one port when that port is expected valid.
    task automatic chk_out(input string tag, input logic [4:0] ev, input int o, input logic [15:0] ed);
        check({tag, "_v"}, 80'(out_valid), 80'(ev));
        if (ev[o]) check({tag, "_d"}, 80'(out_d[o]), 80'(ed));
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        nx();
        rst      = 1'b1;
        in_valid = '0;
        out_full = '0;
        nx();
        rst = 1'b0;
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [15:0] flit;
        bit          head;
        bit          tail;
        int          port;
    } flit_t;

    flit_t exp_q [NP][$];
    flit_t tx_q  [NP][$];
    int    cur_src [NP];
    int    rr      [NP];
    int    body_seq = 0;

    function automatic int xy_port(input int x, input int y);
        if (x > 1) return 2;
        if (x < 1) return 3;
        if (y > 1) return 0;
        if (y < 1) return 1;
        return 4;
    endfunction

    function automatic bit model_empty();
        for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0 || tx_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_packet(input int p);
        int    len, x, y;
        flit_t f;
        len = p + 1 + 5 * $urandom_range(0, 1);
        x   = $urandom_range(0, 3);
        y   = $urandom_range(0, 3);
        for (int i = 0; i < len; i++) begin
            f.flit = (i == 0) ? {8'(len), 4'(x), 4'(y)} : {4'(p), 12'(body_seq)};
            if (i != 0) body_seq++;
            f.head = (i == 0);
            f.tail = (i == len - 1);
            f.port = xy_port(x, y);
            tx_q[p].push_back(f);
        end
    endtask

    task automatic model_cycle(input bit gen, input bit stall);
        flit_t front [NP];
        bit    have [NP];
        bit    popped [NP];
        bit    drv [NP];
        int    s, win;
        nx();
        for (int p = 0; p < NP; p++) begin
            if (gen && tx_q[p].size() == 0 && $urandom_range(0, 1) == 1) gen_packet(p);
            out_full[p] = stall && ($urandom_range(0, 3) == 0);
            drv[p]      = (tx_q[p].size() != 0) && !in_full[p] && ($urandom_range(0, 3) != 0);
            in_valid[p] = drv[p];
            if (drv[p]) in_d[p] = tx_q[p][0].flit;
        end
        #1;
        for (int p = 0; p < NP; p++) begin
            have[p]   = (exp_q[p].size() != 0);
            popped[p] = 1'b0;
            if (have[p]) front[p] = exp_q[p][0];
        end
        for (int o = 0; o < NP; o++) begin
            if (out_full[o]) begin
                check("rnd_stall", 80'(out_valid[o]), 80'(0));
            end else if (cur_src[o] >= 0) begin
                s = cur_src[o];
                check("rnd_locked_v", 80'(out_valid[o]), 80'(have[s]));
                if (have[s]) begin
                    check("rnd_locked_d", 80'(out_d[o]), 80'(front[s].flit));
                    popped[s] = 1'b1;
                    if (front[s].tail) cur_src[o] = -1;
                end
            end else begin
                win = -1;
                for (int k = 0; k < NP; k++) begin
                    s = (rr[o] + k) % NP;
                    if (win < 0 && have[s] && front[s].head && front[s].port == o) win = s;
                end
                check("rnd_grant_v", 80'(out_valid[o]), 80'(win >= 0));
                if (win >= 0) begin
                    check("rnd_grant_d", 80'(out_d[o]), 80'(front[win].flit));
                    popped[win] = 1'b1;
                    rr[o] = (win + 1) % NP;
                    if (!front[win].tail) cur_src[o] = win;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (popped[p]) void'(exp_q[p].pop_front());
            if (drv[p]) exp_q[p].push_back(tx_q[p].pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        out_full = '0;
        for (int p = 0; p < NP; p++) in_d[p] = '0;

        // Reset state
        nx(); nx(); #1;
        check("rst_in_full",   80'(in_full),   80'(0));
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_out_data",  80'(out_data),  80'(0));
        nx();
        rst = 1'b0;

        // W input, L=3 packet to (2,1) leaves on E one cycle later, back-to-back
        nx(); in_valid = 5'b01000; in_d[3] = 16'h0321; #1; chk_out("t1_c0", 5'b00000, 2, 16'h0);
        nx(); in_d[3] = 16'hB001;                      #1; chk_out("t1_c1", 5'b00100, 2, 16'h0321);
        nx(); in_d[3] = 16'hB002;                      #1; chk_out("t1_c2", 5'b00100, 2, 16'hB001);
        nx(); in_valid = '0;                           #1; chk_out("t1_c3", 5'b00100, 2, 16'hB002);
        nx();                                          #1; chk_out("t1_c4", 5'b00000, 2, 16'h0);

        // XY routing: local->(1,2)=N, N->(1,0)=S, S->(1,1)=local, E->(0,3)=W
        nx();
        in_valid = 5'b10111;
        in_d[4] = 16'h0112; in_d[0] = 16'h0110; in_d[1] = 16'h0111; in_d[2] = 16'h0103;
        nx(); in_valid = '0; #1;
        check("t2_valid", 80'(out_valid), 80'(5'b11011));
        check("t2_n",     80'(out_d[0]),  80'(16'h0112));
        check("t2_s",     80'(out_d[1]),  80'(16'h0110));
        check("t2_w",     80'(out_d[3]),  80'(16'h0103));
        check("t2_l",     80'(out_d[4]),  80'(16'h0111));
        nx(); #1; check("t2_idle", 80'(out_valid), 80'(0));

        // N and S contend for E with L=2 packets; N queues a second packet, S must win in between
        nx(); in_valid = 5'b00011; in_d[0] = 16'h0221; in_d[1] = 16'h0221; #1;
        chk_out("t3_c0", 5'b00000, 2, 16'h0);
        nx(); in_d[0] = 16'hA001; in_d[1] = 16'hC001; #1; chk_out("t3_c1", 5'b00100, 2, 16'h0221);
        nx(); in_valid = 5'b00001; in_d[0] = 16'h0221; #1; chk_out("t3_c2", 5'b00100, 2, 16'hA001);
        nx(); in_d[0] = 16'hA002;                     #1; chk_out("t3_c3", 5'b00100, 2, 16'h0221);
        nx(); in_valid = '0;                          #1; chk_out("t3_c4", 5'b00100, 2, 16'hC001);
        nx();                                         #1; chk_out("t3_c5", 5'b00100, 2, 16'h0221);
        nx();                                         #1; chk_out("t3_c6", 5'b00100, 2, 16'hA002);
        nx();                                         #1; chk_out("t3_c7", 5'b00000, 2, 16'h0);

        // Backpressure: E held full, 6 flits offered on W; only 4 are stored
        nx(); out_full = 5'b00100; in_valid = 5'b01000; in_d[3] = 16'h0421; #1;
        check("t4_full0", 80'(in_full), 80'(0));
        for (int i = 1; i <= 5; i++) begin
            nx(); in_d[3] = 16'hD000 + 16'(i); #1;
            check("t4_full", 80'(in_full), 80'((i >= 4) ? 5'b01000 : 5'b00000));
            check("t4_hold", 80'(out_valid), 80'(0));
        end
        nx(); in_valid = '0; #1;
        check("t4_full6", 80'(in_full), 80'(5'b01000));
        nx(); out_full = '0; #1;
        chk_out("t4_d0", 5'b00100, 2, 16'h0421);
        check("t4_full_pop", 80'(in_full), 80'(5'b01000));
        nx(); #1;
        chk_out("t4_d1", 5'b00100, 2, 16'hD001);
        check("t4_full_rel", 80'(in_full), 80'(0));
        nx(); #1; chk_out("t4_d2", 5'b00100, 2, 16'hD002);
        nx(); #1; chk_out("t4_d3", 5'b00100, 2, 16'hD003);
        nx(); #1; chk_out("t4_d4", 5'b00000, 2, 16'h0);

        // Reset in the middle of an L=5 packet, then contention right after reset
        nx(); in_valid = 5'b01000; in_d[3] = 16'h0521; #1; chk_out("t5_c0", 5'b00000, 2, 16'h0);
        nx(); in_d[3] = 16'hE001;                      #1; chk_out("t5_c1", 5'b00100, 2, 16'h0521);
        nx(); in_d[3] = 16'hE002;                      #1; chk_out("t5_c2", 5'b00100, 2, 16'hE001);
        #2; rst = 1'b1; in_valid = '0; #1;
        check("t5_rst_valid", 80'(out_valid), 80'(0));
        check("t5_rst_data",  80'(out_data),  80'(0));
        check("t5_rst_full",  80'(in_full),   80'(0));
        nx(); rst = 1'b0; #1;
        check("t5_post_valid", 80'(out_valid), 80'(0));
        nx(); in_valid = 5'b10001; in_d[0] = 16'h0130; in_d[4] = 16'h0121; #1;
        chk_out("t5_n0", 5'b00000, 2, 16'h0);
        nx(); in_valid = '0; #1; chk_out("t5_n1", 5'b00100, 2, 16'h0130);
        nx();                #1; chk_out("t5_n2", 5'b00100, 2, 16'h0121);
        nx();                #1; chk_out("t5_n3", 5'b00000, 2, 16'h0);

        // L=0 behaves as a single flit: the next head on W is routed on its own
        nx(); in_valid = 5'b01000; in_d[3] = 16'h0021; #1; chk_out("t6_c0", 5'b00000, 2, 16'h0);
        nx(); in_d[3] = 16'h0112;                      #1; chk_out("t6_c1", 5'b00100, 2, 16'h0021);
        nx(); in_valid = '0;                           #1; chk_out("t6_c2", 5'b00001, 0, 16'h0112);
        nx();                                          #1; chk_out("t6_c3", 5'b00000, 0, 16'h0);

        // Randomized traffic against the queue model
        pulse_reset();
        for (int p = 0; p < NP; p++) begin
            cur_src[p] = -1;
            rr[p]      = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            model_cycle(c < 800, c < 800);
            if (c >= 800 && model_empty()) break;
        end
        check("rnd_drained", 80'(model_empty()), 80'(1));
        in_valid = '0;
        out_full = '0;

`ifdef ROUTER_STATS_EN
        // Five flits forwarded on E: 16-bit counter reads 5, 2-bit counter saturates at 3
        pulse_reset();
        in_valid = 5'b01000; in_d[3] = 16'h0521;
        for (int i = 1; i < 5; i++) begin
            nx(); in_d[3] = 16'hF000 + 16'(i);
        end
        nx(); in_valid = '0;
        nx(); nx(); nx(); nx(); #1;
        check("stats_cnt", 80'(flit_cnt), 80'({16'd0, 16'd0, 16'd5, 16'd0, 16'd0}));
        check("stats_sat", 80'(sat_cnt),  80'({2'd0, 2'd0, 2'd3, 2'd0, 2'd0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
